// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types/constants for the sequential binary-to-BCD converter.
// Holds FSM encoding, digit width and the all-nines saturation pattern.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_FIVE    = 4'd5;
  localparam logic [3:0] BCD_NINE    = 4'd9;

  // All-nines pattern for up to 16 digits; caller keeps the low 4*digits.
  function automatic logic [63:0] all_nines_f(input int digits);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < digits) r[4*i +: 4] = BCD_NINE;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One BCD digit correction step of shift-and-add-3: +3 when digit >= 5.
// Ports: digit_i (4-bit BCD digit in), digit_o (corrected digit out).
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= BCD_FIVE) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, start/busy/done.
// Ports: clk, rst (async, active high), start, bin -> busy, done, bcd, ovf.
// Option: define BIN2BCD_SAT_EN to saturate bcd to all nines with ovf=1.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int W_BIN  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W_BIN-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CW    = $clog2(W_BIN + 1);

  state_e           state_q, state_d;
  logic [W_BIN-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0] acc_q, acc_d, adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             accept, in_busy, last;

  assign in_busy = (state_q == ST_BUSY);
  assign accept  = start && !in_busy;
  assign last    = in_busy && (cnt_q == CW'(1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: if (last)  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift datapath: load on accept, add-3 then shift while busy
  always_comb begin
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (accept) begin
      shreg_d = bin;
      acc_d   = '0;
      cnt_d   = CW'(W_BIN);
    end else if (in_busy) begin
      acc_d   = {adj[BCD_W-2:0], shreg_q[W_BIN-1]};
      shreg_d = {shreg_q[W_BIN-2:0], 1'b0};
      cnt_d   = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BIN2BCD_SAT_EN
  localparam logic [63:0] NINES64 = all_nines_f(DIGITS);

  // Sticky: a carry out of the top digit carries weight 10^DIGITS
  logic sticky_q, sticky_d, ovf_q, ovf_d;

  always_comb begin
    sticky_d = sticky_q;
    if (accept)       sticky_d = 1'b0;
    else if (in_busy) sticky_d = sticky_q | adj[BCD_W-1];
  end

  assign ovf_d = sticky_q | adj[BCD_W-1];
  assign bcd_d = ovf_d ? NINES64[BCD_W-1:0] : acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      if (last) ovf_q <= ovf_d;
    end
  end
`else
  // Dropped top carry gives natural mod 10^DIGITS truncation
  logic unused_top;
  logic ovf_q;
  assign unused_top = adj[BCD_W-1];
  assign ovf_q      = 1'b0;
  assign bcd_d      = acc_d;
`endif

  // Result register, loaded only on the final shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       bcd_q <= '0;
    else if (last) bcd_q <= bcd_d;
  end

  // Outputs
  always_comb begin
    busy = (state_q == ST_BUSY);
    done = (state_q == ST_DONE);
    bcd  = bcd_q;
    ovf  = ovf_q;
  end

endmodule
